// File: rtl/risc_core_p.sv
// risc_core_p: accumulator-based multi-cycle core (HALT/FETCH/DECODE/EXEC) driving a
// single request/acknowledge memory port; all memory-port outputs are registered.
module risc_core_p #(
   parameter int ADR_W = 5,
   localparam int DATA_W = ADR_W + 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADR_W-1:0]  mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [ADR_W-1:0]  pc_out,
   output logic [DATA_W-1:0] ac_out,
   output logic [2:0]        op_code,
   output logic              zero_flag,
   output logic              carry_flag
);
   typedef enum logic [1:0] {HALT, FETCH, DECODE, EXEC} state_t;
   localparam logic [2:0] LDA = 3'd0, STA = 3'd1, ADD = 3'd2, SUB = 3'd3, JMP = 3'd5, JZ = 3'd6, HLT = 3'd7;
   state_t state;
   logic [ADR_W-1:0] pc, operand;
   logic [DATA_W-1:0] ac, ir, res;
   logic [DATA_W:0] sum, dif;
   logic z, c;
   assign op_code = ir[DATA_W-1 -: 3];
   assign operand = ir[ADR_W-1:0];
   assign sum = {1'b0, ac} + {1'b0, mem_rdata};
   assign dif = {1'b0, ac} - {1'b0, mem_rdata};
   assign mem_wdata = ac;
   assign pc_out = pc;
   assign ac_out = ac;
   assign zero_flag = z;
   assign carry_flag = c;
   always_comb res = op_code == LDA ? mem_rdata : op_code == ADD ? sum[DATA_W-1:0] :
                     op_code == SUB ? dif[DATA_W-1:0] : ac & mem_rdata;
   // The top bit of dif is set exactly when AC < M, i.e. the borrow out.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= HALT;
         pc <= '0;
         ac <= '0;
         ir <= '0;
         z <= 1'b0;
         c <= 1'b0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_adr <= '0;
         halted <= 1'b1;
      end else
         case (state)
            HALT: if (run) begin
               state <= FETCH;
               halted <= 1'b0;
               mem_req <= 1'b1;
               mem_we <= 1'b0;
               mem_adr <= pc;
            end
            FETCH: if (mem_ack) begin
               ir <= mem_rdata;
               pc <= pc + 1'b1;
               state <= DECODE;
               mem_req <= 1'b0;
            end
            DECODE:
               if (op_code == HLT) begin
                  state <= HALT;
                  halted <= 1'b1;
               end else if (op_code == JMP || op_code == JZ) begin
                  pc <= (op_code == JMP || z) ? operand : pc;
                  mem_adr <= (op_code == JMP || z) ? operand : pc;
                  state <= FETCH;
                  mem_req <= 1'b1;
                  mem_we <= 1'b0;
               end else begin
                  state <= EXEC;
                  mem_req <= 1'b1;
                  mem_we <= op_code == STA;
                  mem_adr <= operand;
               end
            EXEC: if (mem_ack) begin
               if (op_code != STA) begin
                  ac <= res;
                  z <= res == '0;
               end
               if (op_code == ADD || op_code == SUB) c <= op_code == ADD ? sum[DATA_W] : dif[DATA_W];
               state <= FETCH;
               mem_req <= 1'b1;
               mem_we <= 1'b0;
               mem_adr <= pc;
            end
            default: state <= HALT;
         endcase
endmodule

// File: tb/tb_risc_core_p.sv
// tb_risc_core_p: table-driven ALU vectors plus hand sequences for handshake, wrap and reset.
module tb_risc_core_p;
   logic clk = 0, rst_n = 0, run = 0;
   logic mem_req, mem_we, mem_ack, halted, zero_flag, carry_flag;
   logic [4:0] mem_adr, pc_out;
   logic [7:0] mem_wdata, mem_rdata, ac_out;
   logic [2:0] op_code;
   logic [7:0] mem [32];
   int dly = 0, wcnt = 0, total = 0, passed = 0;
   logic ack_force = 0, mon = 0, prev_wait = 0, prev_we = 0;
   logic [4:0] prev_adr = 0;
   risc_core_p #(.ADR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .mem_req(mem_req), .mem_we(mem_we),
      .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .halted(halted), .pc_out(pc_out), .ac_out(ac_out), .op_code(op_code),
      .zero_flag(zero_flag), .carry_flag(carry_flag)
   );
   always #5 clk = ~clk;
   // Memory acks after dly waiting cycles; ack_force injects stray acks.
   assign mem_ack = (mem_req && wcnt >= dly) || ack_force;
   assign mem_rdata = mem[mem_adr];
   always @(posedge clk) begin
      if (mem_req && mem_we && mem_ack) mem[mem_adr] <= mem_wdata;
      wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a === e) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask
   always @(negedge clk) begin
      if (mon && prev_wait && rst_n) begin
         chk("wait_req", {31'd0, mem_req}, 1);
         chk("wait_adr", {27'd0, mem_adr}, {27'd0, prev_adr});
         chk("wait_we", {31'd0, mem_we}, {31'd0, prev_we});
      end
      prev_wait <= mem_req && !mem_ack;
      prev_adr <= mem_adr;
      prev_we <= mem_we;
   end
   task automatic reset_core();
      @(negedge clk);
      rst_n = 0;
      for (int j = 0; j < 32; j++) mem[j] = 8'h00;
      @(negedge clk);
      rst_n = 1;
   endtask
   task automatic pulse_run();
      @(negedge clk);
      run = 1;
      @(negedge clk);
      run = 0;
   endtask
   task automatic go(output int cyc);
      pulse_run();
      cyc = 1;
      while (!halted && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      chk("halt_timeout", {31'd0, cyc < 500}, 1);
   endtask
   typedef struct {
      logic [2:0] op;
      logic [7:0] a, m, ac, mo;
      logic c, z;
   } vec_t;
   vec_t v [11];
   initial begin
      int cyc;
      v[0]  = '{3'd0, 8'h12, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
      v[1]  = '{3'd2, 8'h12, 8'h34, 8'h46, 8'h34, 1'b0, 1'b0};
      v[2]  = '{3'd2, 8'hFF, 8'h01, 8'h00, 8'h01, 1'b1, 1'b1};
      v[3]  = '{3'd2, 8'h80, 8'h90, 8'h10, 8'h90, 1'b1, 1'b0};
      v[4]  = '{3'd3, 8'h50, 8'h20, 8'h30, 8'h20, 1'b0, 1'b0};
      v[5]  = '{3'd3, 8'h00, 8'h01, 8'hFF, 8'h01, 1'b1, 1'b0};
      v[6]  = '{3'd3, 8'h7F, 8'h7F, 8'h00, 8'h7F, 1'b0, 1'b1};
      v[7]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 8'h3C, 1'b0, 1'b0};
      v[8]  = '{3'd4, 8'hAA, 8'h55, 8'h00, 8'h55, 1'b0, 1'b1};
      v[9]  = '{3'd1, 8'h00, 8'h11, 8'h00, 8'h00, 1'b0, 1'b1};
      v[10] = '{3'd1, 8'h5A, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0};
      reset_core();
      chk("rst_halted", {31'd0, halted}, 1);
      chk("rst_pc", {27'd0, pc_out}, 0);
      chk("rst_ac", {24'd0, ac_out}, 0);
      chk("rst_req", {31'd0, mem_req}, 0);
      chk("rst_flags", {30'd0, zero_flag, carry_flag}, 0);
      chk("rst_op", {29'd0, op_code}, 0);
      for (int i = 0; i < 11; i++) begin
         reset_core();
         mem[0] = 8'h14;
         mem[1] = {v[i].op, 5'd21};
         mem[2] = 8'hE0;
         mem[20] = v[i].a;
         mem[21] = v[i].m;
         go(cyc);
         chk($sformatf("v%0d_ac", i), {24'd0, ac_out}, {24'd0, v[i].ac});
         chk($sformatf("v%0d_c", i), {31'd0, carry_flag}, {31'd0, v[i].c});
         chk($sformatf("v%0d_z", i), {31'd0, zero_flag}, {31'd0, v[i].z});
         chk($sformatf("v%0d_pc", i), {27'd0, pc_out}, 3);
         chk($sformatf("v%0d_mem", i), {24'd0, mem[21]}, {24'd0, v[i].mo});
         chk($sformatf("v%0d_cycles", i), cyc, 9);
      end
      // Reference program, then resume after HLT with an AND that must keep C.
      for (int w = 0; w < 2; w++) begin
         reset_core();
         mem[0] = 8'h0A; mem[1] = 8'h4B; mem[2] = 8'h2C; mem[3] = 8'hE0;
         mem[10] = 8'hF0; mem[11] = 8'h20;
         dly = w * 3;
         mon = w == 1;
         go(cyc);
         mon = 0;
         dly = 0;
         chk($sformatf("prog%0d_ac", w), {24'd0, ac_out}, 8'h10);
         chk($sformatf("prog%0d_c", w), {31'd0, carry_flag}, 1);
         chk($sformatf("prog%0d_z", w), {31'd0, zero_flag}, 0);
         chk($sformatf("prog%0d_m12", w), {24'd0, mem[12]}, 8'h10);
         chk($sformatf("prog%0d_pc", w), {27'd0, pc_out}, 4);
         chk($sformatf("prog%0d_cycles", w), cyc, w == 1 ? 33 : 12);
      end
      mem[4] = 8'h8D; mem[5] = 8'hE0; mem[13] = 8'h30;
      go(cyc);
      chk("and_ac", {24'd0, ac_out}, 8'h10);
      chk("and_c_kept", {31'd0, carry_flag}, 1);
      chk("and_pc", {27'd0, pc_out}, 6);
      // SUB then JZ: taken when the result is zero, falls through otherwise.
      for (int k = 0; k < 2; k++) begin
         reset_core();
         mem[0] = 8'h16; mem[1] = 8'h77; mem[2] = 8'hD4; mem[3] = 8'hE0; mem[20] = 8'hE0;
         mem[22] = 8'h05; mem[23] = k == 0 ? 8'h05 : 8'h06;
         go(cyc);
         chk($sformatf("jz%0d_ac", k), {24'd0, ac_out}, k == 0 ? 8'h00 : 8'hFF);
         chk($sformatf("jz%0d_z", k), {31'd0, zero_flag}, k == 0 ? 1 : 0);
         chk($sformatf("jz%0d_c", k), {31'd0, carry_flag}, k == 0 ? 0 : 1);
         chk($sformatf("jz%0d_pc", k), {27'd0, pc_out}, k == 0 ? 21 : 4);
      end
      // Stray acks in HALT are ignored.
      reset_core();
      mem[0] = 8'hBF; mem[31] = 8'hA0;
      ack_force = 1;
      @(negedge clk);
      @(negedge clk);
      ack_force = 0;
      chk("halt_ack_op", {29'd0, op_code}, 0);
      chk("halt_ack_pc", {27'd0, pc_out}, 0);
      chk("halt_ack_halted", {31'd0, halted}, 1);
      // JMP 31 / JMP 0 loop: PC wrap, run and stray acks ignored while running.
      pulse_run();
      @(negedge clk);
      chk("wrap_pc1", {27'd0, pc_out}, 1);
      chk("wrap_op1", {29'd0, op_code}, 5);
      @(negedge clk);
      chk("wrap_pc31", {27'd0, pc_out}, 31);
      chk("wrap_adr31", {27'd0, mem_adr}, 31);
      @(negedge clk);
      chk("wrap_pc0", {27'd0, pc_out}, 0);
      chk("wrap_req_low", {31'd0, mem_req}, 0);
      run = 1;
      ack_force = 1;
      @(negedge clk);
      ack_force = 0;
      chk("wrap_adr0", {27'd0, mem_adr}, 0);
      chk("wrap_req", {31'd0, mem_req}, 1);
      chk("wrap_pc_hold", {27'd0, pc_out}, 0);
      @(negedge clk);
      run = 0;
      chk("wrap_pc_next", {27'd0, pc_out}, 1);
      chk("wrap_running", {31'd0, halted}, 0);
      // Reset while EXEC waits for an ack; the late ack is ignored.
      reset_core();
      mem[0] = 8'h0A; mem[1] = 8'h0B; mem[10] = 8'h33; mem[11] = 8'h44;
      pulse_run();
      repeat (4) @(negedge clk);
      dly = 100;
      @(negedge clk);
      chk("exec_wait_req", {31'd0, mem_req}, 1);
      chk("exec_wait_adr", {27'd0, mem_adr}, 11);
      chk("exec_wait_ac", {24'd0, ac_out}, 8'h33);
      repeat (2) @(negedge clk);
      chk("exec_still_wait", {31'd0, mem_req}, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_req", {31'd0, mem_req}, 0);
      chk("arst_pc", {27'd0, pc_out}, 0);
      chk("arst_ac", {24'd0, ac_out}, 0);
      chk("arst_halted", {31'd0, halted}, 1);
      @(negedge clk);
      rst_n = 1;
      dly = 0;
      ack_force = 1;
      repeat (2) @(negedge clk);
      ack_force = 0;
      chk("late_ack_halted", {31'd0, halted}, 1);
      chk("late_ack_pc", {27'd0, pc_out}, 0);
      chk("late_ack_ac", {24'd0, ac_out}, 0);
      chk("late_ack_req", {31'd0, mem_req}, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
